// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_pkg
// Purpose  : Immediate format codes and reference decode of packed raw bits
//            (instruction bits [31:7]) back to the architectural immediate.
// Revision : 1.0 - initial release
// ============================================================================
package imm_pkg;

  typedef enum logic [2:0] {
    SRC_I = 3'b000,
    SRC_S = 3'b001,
    SRC_B = 3'b010,
    SRC_J = 3'b011,
    SRC_U = 3'b100
  } imm_source_e;

  localparam int RAW_W = 25;

  // raw[k] corresponds to instruction bit k+7
  function automatic logic [31:0] imm_decode(input logic [RAW_W-1:0] raw,
                                             input logic [2:0]       src);
    logic [31:0] imm;
    imm = '0;
    case (src)
      SRC_I:   imm = {{20{raw[24]}}, raw[24:13]};
      SRC_S:   imm = {{20{raw[24]}}, raw[24:18], raw[4:0]};
      SRC_B:   imm = {{19{raw[24]}}, raw[24], raw[0], raw[23:18], raw[4:1], 1'b0};
      SRC_J:   imm = {{11{raw[24]}}, raw[24], raw[12:5], raw[13], raw[23:14], 1'b0};
      SRC_U:   imm = {raw[24:5], 12'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_range_check.sv
`default_nettype none
// ============================================================================
// Module   : imm_range_check
// Purpose  : Combinational check that an immediate is representable in the
//            selected format; illegal format codes always flag an error.
// Revision : 1.0 - initial release
// ============================================================================
module imm_range_check
  import imm_pkg::*;
(
  input  logic [31:0] imm_i,
  input  logic [2:0]  src_i,
  output logic        range_err_o
);

  logic w_hi11_same;
  logic w_hi12_same;
  logic w_hi20_same;

  // Sign-extension checks: the upper bits must be all ones or all zeros
  assign w_hi11_same = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign w_hi12_same = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign w_hi20_same = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  // Select the representability rule of the requested format
  always_comb begin
    range_err_o = 1'b1;
    case (src_i)
      SRC_I:   range_err_o = ~w_hi11_same;
      SRC_S:   range_err_o = ~w_hi11_same;
      SRC_B:   range_err_o = ~w_hi12_same | imm_i[0];
      SRC_J:   range_err_o = ~w_hi20_same | imm_i[0];
      SRC_U:   range_err_o = |imm_i[11:0];
      default: range_err_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : imm_encoder
// Purpose  : Two-stage valid/ready pipeline packing an architectural
//            immediate into instruction bits [31:7], with range checking and
//            a saturating count of delivered range errors.
// Revision : 1.0 - initial release
// ============================================================================
module imm_encoder
  import imm_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_imm,
  input  logic [2:0]           in_imm_source,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RAW_W-1:0]     out_raw,
  output logic                 out_range_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic                 s1_valid_q, s1_valid_d;
  logic [31:0]          s1_imm_q,   s1_imm_d;
  logic [2:0]           s1_src_q,   s1_src_d;
  logic                 s1_err_q,   s1_err_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [RAW_W-1:0]     raw_q,      raw_d;
  logic                 err_q,      err_d;
  logic [ERR_CNT_W-1:0] cnt_q,      cnt_d;

  logic                 w_range_err;
  logic                 w_s2_ready;
  logic [RAW_W-1:0]     w_packed;

  imm_range_check u_range_check (
    .imm_i       (in_imm),
    .src_i       (in_imm_source),
    .range_err_o (w_range_err)
  );

  // S2 can take new data when empty or draining; S1 likewise when S2 can
  assign w_s2_ready    = ~s2_valid_q | out_ready;
  assign in_ready      = ~s1_valid_q | w_s2_ready;
  assign out_valid     = s2_valid_q;
  assign out_raw       = raw_q;
  assign out_range_err = err_q;
  assign err_count     = cnt_q;

  // Scatter the S1 immediate into instruction-bit positions; illegal -> zero
  always_comb begin
    w_packed = '0;
    case (s1_src_q)
      SRC_I: w_packed[24:13] = s1_imm_q[11:0];
      SRC_S: begin
        w_packed[24:18] = s1_imm_q[11:5];
        w_packed[4:0]   = s1_imm_q[4:0];
      end
      SRC_B: begin
        w_packed[24]    = s1_imm_q[12];
        w_packed[23:18] = s1_imm_q[10:5];
        w_packed[4:1]   = s1_imm_q[4:1];
        w_packed[0]     = s1_imm_q[11];
      end
      SRC_J: begin
        w_packed[24]    = s1_imm_q[20];
        w_packed[23:14] = s1_imm_q[10:1];
        w_packed[13]    = s1_imm_q[11];
        w_packed[12:5]  = s1_imm_q[19:12];
      end
      SRC_U:   w_packed[24:5] = s1_imm_q[31:12];
      default: w_packed = '0;
    endcase
  end

  // Next-state for both stages and the saturating error counter
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_imm_d   = s1_imm_q;
    s1_src_d   = s1_src_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    raw_d      = raw_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_imm_d = in_imm;
        s1_src_d = in_imm_source;
        s1_err_d = w_range_err;
      end
    end
    if (w_s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        raw_d = w_packed;
        err_d = s1_err_q;
      end
    end
    if (s2_valid_q && out_ready && err_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers; reset empties the pipe and clears visible outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_imm_q   <= '0;
      s1_src_q   <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      raw_q      <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_imm_q   <= s1_imm_d;
      s1_src_q   <= s1_src_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      raw_q      <= raw_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_encoder
// Purpose  : Self-checking bench for imm_encoder with a bit-placement
//            reference model and an in-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_imm;
  logic [2:0]  in_imm_source;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_raw;
  logic        out_range_err;
  logic [7:0]  err_count;

  imm_encoder #(.ERR_CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_imm        (in_imm),
    .in_imm_source (in_imm_source),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_raw       (out_raw),
    .out_range_err (out_range_err),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] raw;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          n_out = 0;
  int          exp_cnt = 0;
  logic        held_v = 1'b0;
  logic [24:0] held_raw;
  logic        held_err;
  logic        last_acc;

  // Representability from the signed value's numeric range
  function automatic logic model_err(input logic [2:0] src, input logic [31:0] imm);
    longint s;
    s = longint'($signed(imm));
    case (src)
      3'd0, 3'd1: return !(s >= -2048 && s <= 2047);
      3'd2:       return !(s >= -4096 && s <= 4095 && (s % 2) == 0);
      3'd3:       return !(s >= -(64'sd1 <<< 20) && s <= (64'sd1 <<< 20) - 1 && (s % 2) == 0);
      3'd4:       return (imm % 4096) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  // Place immediate bits at their instruction-word positions, then drop [6:0]
  function automatic logic [24:0] model_raw(input logic [2:0] src, input logic [31:0] imm);
    logic [31:0] ins;
    ins = '0;
    case (src)
      3'd0: for (int k = 0; k < 12; k++) ins[20+k] = imm[k];
      3'd1: begin
        for (int k = 0; k < 5; k++)  ins[7+k]  = imm[k];
        for (int k = 5; k < 12; k++) ins[20+k] = imm[k];
      end
      3'd2: begin
        for (int k = 1; k < 5; k++)  ins[7+k]  = imm[k];
        for (int k = 5; k < 11; k++) ins[20+k] = imm[k];
        ins[7]  = imm[11];
        ins[31] = imm[12];
      end
      3'd3: begin
        for (int k = 1; k < 11; k++)  ins[20+k] = imm[k];
        ins[20] = imm[11];
        for (int k = 12; k < 20; k++) ins[k] = imm[k];
        ins[31] = imm[20];
      end
      3'd4: for (int k = 12; k < 32; k++) ins[k] = imm[k];
      default: ins = '0;
    endcase
    return ins[31:7];
  endfunction

  function automatic logic [31:0] rand_legal(input logic [2:0] src);
    int v;
    case (src)
      3'd0, 3'd1: v = int'($urandom_range(0, 4095)) - 2048;
      3'd2:       v = int'($urandom_range(0, 4095)) * 2 - 4096;
      3'd3:       v = int'($urandom_range(0, (1 << 20) - 1)) * 2 - (1 << 20);
      default:    v = int'($urandom & 32'hFFFFF000);
    endcase
    return 32'(v);
  endfunction

  // One clock: drive, observe mid-cycle, score any transfer at the next edge
  task automatic step(input logic v, input logic [31:0] imm, input logic [2:0] src,
                      input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_imm = imm; in_imm_source = src; out_ready = ordy;
    #1;
    total++;
    if (err_count !== 8'(exp_cnt)) begin
      bad++;
      $display("FAIL err_count: got %0d want %0d", err_count, exp_cnt);
    end
    if (held_v) begin
      total++;
      if (out_valid !== 1'b1 || out_raw !== held_raw || out_range_err !== held_err) begin
        bad++;
        $display("FAIL stall_hold: got v=%b raw=%h err=%b want v=1 raw=%h err=%b",
                 out_valid, out_raw, out_range_err, held_raw, held_err);
      end
    end
    last_acc = v && (in_ready === 1'b1);
    if (out_valid === 1'b1 && ordy) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL spurious_out: got raw=%h err=%b want no output", out_raw, out_range_err);
      end else begin
        e = q.pop_front();
        n_out++;
        if (out_raw !== e.raw || out_range_err !== e.err) begin
          bad++;
          $display("FAIL out_data: got raw=%h err=%b want raw=%h err=%b",
                   out_raw, out_range_err, e.raw, e.err);
        end
        if (e.err && exp_cnt < 255) exp_cnt++;
      end
    end
    held_v   = (out_valid === 1'b1) && !ordy;
    held_raw = out_raw;
    held_err = out_range_err;
    if (last_acc) q.push_back('{model_raw(src, imm), model_err(src, imm)});
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      step(1'b0, 32'h0, 3'd0, 1'b1);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_imm = '0; in_imm_source = '0; out_ready = 1'b0;
    #2;
    total++;
    if (out_valid !== 1'b0 || out_raw !== 25'h0 || out_range_err !== 1'b0 || err_count !== 8'h0) begin
      bad++;
      $display("FAIL reset_state: got v=%b raw=%h err=%b cnt=%0d want all 0",
               out_valid, out_raw, out_range_err, err_count);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    step(1'b0, 32'h0, 3'd0, 1'b1);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_i_latency();
    step(1'b1, 32'hFFFFF800, 3'd0, 1'b1);
    step(1'b0, 32'h0, 3'd0, 1'b1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL i_latency_early: got out_valid=%b want 0", out_valid);
    end
    step(1'b0, 32'h0, 3'd0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_raw !== 25'h1000000 || out_range_err !== 1'b0) begin
      bad++;
      $display("FAIL i_example: got v=%b raw=%h err=%b want v=1 raw=1000000 err=0",
               out_valid, out_raw, out_range_err);
    end
  endtask

  task automatic test_b_odd();
    step(1'b1, 32'h00001001, 3'd2, 1'b1);
    total++;
    if (err_count !== 8'd0) begin
      bad++;
      $display("FAIL b_cnt_before: got %0d want 0", err_count);
    end
    step(1'b0, 32'h0, 3'd0, 1'b1);
    step(1'b0, 32'h0, 3'd0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_range_err !== 1'b1) begin
      bad++;
      $display("FAIL b_odd_err: got v=%b err=%b want v=1 err=1", out_valid, out_range_err);
    end
    step(1'b0, 32'h0, 3'd0, 1'b1);
    total++;
    if (err_count !== 8'd1) begin
      bad++;
      $display("FAIL b_cnt_after: got %0d want 1", err_count);
    end
  endtask

  task automatic test_u();
    step(1'b1, 32'h12345000, 3'd4, 1'b1);
    step(1'b1, 32'h12345001, 3'd4, 1'b1);
    step(1'b0, 32'h0, 3'd0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_raw !== 25'h02468A0 || out_range_err !== 1'b0) begin
      bad++;
      $display("FAIL u_legal: got v=%b raw=%h err=%b want v=1 raw=02468a0 err=0",
               out_valid, out_raw, out_range_err);
    end
    step(1'b0, 32'h0, 3'd0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_range_err !== 1'b1) begin
      bad++;
      $display("FAIL u_low_bits: got v=%b err=%b want v=1 err=1", out_valid, out_range_err);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int cyc  = 0;
    int start_out;
    logic [31:0] imm;
    start_out = n_out;
    imm = rand_legal(3'd3);
    while (sent < 8 && cyc < 100) begin
      step(1'b1, imm, 3'd3, (cyc % 4 == 0) || (cyc % 4 == 3));
      if (last_acc) begin
        sent++;
        imm = rand_legal(3'd3);
      end
      cyc++;
    end
    drain();
    total++;
    if (n_out - start_out != 8 || sent != 8) begin
      bad++;
      $display("FAIL j_stream_count: got sent=%0d out=%0d want 8/8", sent, n_out - start_out);
    end
  endtask

  task automatic test_reset_inflight();
    step(1'b1, 32'h0, 3'd6, 1'b1);
    step(1'b1, 32'h0, 3'd7, 1'b1);
    drain();
    step(1'b0, 32'h0, 3'd0, 1'b1);
    step(1'b1, 32'h00000123, 3'd0, 1'b0);
    step(1'b1, 32'h00000ABC, 3'd5, 1'b0);
    step(1'b0, 32'h0, 3'd0, 1'b0);
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || err_count === 8'd0) begin
      bad++;
      $display("FAIL pre_reset_full: got v=%b in_ready=%b cnt=%0d want v=1 in_ready=0 cnt>0",
               out_valid, in_ready, err_count);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || err_count !== 8'd0 || out_raw !== 25'h0 || out_range_err !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got v=%b cnt=%0d raw=%h err=%b want all 0",
               out_valid, err_count, out_raw, out_range_err);
    end
    q.delete(); exp_cnt = 0; held_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 32'h0, 3'd0, 1'b0);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, 3'd0, 1'b1);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_ghost: got out_valid=%b want 0", out_valid);
      end
    end
  endtask

  task automatic test_random_decode();
    logic [31:0] imm;
    for (int f = 0; f < 5; f++) begin
      for (int n = 0; n < 16; n++) begin
        imm = rand_legal(3'(f));
        step(1'b1, imm, 3'(f), 1'b1);
        step(1'b0, 32'h0, 3'd0, 1'b1);
        step(1'b0, 32'h0, 3'd0, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_range_err !== 1'b0 ||
            imm_pkg::imm_decode(out_raw, 3'(f)) !== imm) begin
          bad++;
          $display("FAIL decode_fmt%0d: got v=%b err=%b dec=%h want v=1 err=0 dec=%h", f,
                   out_valid, out_range_err, imm_pkg::imm_decode(out_raw, 3'(f)), imm);
        end
      end
    end
    // Mixed stream: any format, legal or arbitrary values, random stalls
    for (int n = 0; n < 200; n++) begin
      logic [2:0] src;
      src = 3'($urandom_range(0, 7));
      imm = ($urandom_range(0, 1) == 1) ? rand_legal(src) : $urandom;
      step(1'($urandom_range(0, 1)), imm, src, 1'($urandom_range(0, 1)));
    end
    drain();
  endtask

  task automatic test_saturation();
    int sent = 0;
    int cyc  = 0;
    while (sent < 300 && cyc < 1000) begin
      step(1'b1, $urandom, 3'd5 + 3'($urandom_range(0, 2)), 1'b1);
      if (last_acc) sent++;
      cyc++;
    end
    drain();
    step(1'b0, 32'h0, 3'd0, 1'b1);
    total++;
    if (err_count !== 8'd255) begin
      bad++;
      $display("FAIL err_saturate: got %0d want 255", err_count);
    end
  endtask

  initial begin
    test_reset();
    test_i_latency();
    test_b_odd();
    test_u();
    test_back_to_back();
    test_reset_inflight();
    test_random_decode();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
